// File: rtl/fft8_pipelined.sv
// rtl/fft8_pipelined.sv - pipelined 8-point radix-2 DIT complex DFT, 5-bit in / 7-bit saturated out; optional input register via FFT8_IN_REG_EN
module fft8_pipelined (
    input  logic              clk,
    input  logic              rst_n,
    input  logic signed [4:0] x_r_0, x_r_1, x_r_2, x_r_3, x_r_4, x_r_5, x_r_6, x_r_7,
    input  logic signed [4:0] x_i_0, x_i_1, x_i_2, x_i_3, x_i_4, x_i_5, x_i_6, x_i_7,
    output logic signed [6:0] y_r_0, y_r_1, y_r_2, y_r_3, y_r_4, y_r_5, y_r_6, y_r_7,
    output logic signed [6:0] y_i_0, y_i_1, y_i_2, y_i_3, y_i_4, y_i_5, y_i_6, y_i_7
);
    // Stage-1 pair k takes samples (BR[2k], BR[2k+1]) so the bins come out in natural order.
    localparam int BR [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic signed [4:0] xp_r [8];
    logic signed [4:0] xp_i [8];
    logic signed [4:0] a_r  [8];
    logic signed [4:0] a_i  [8];
    logic signed [5:0] s1_r_d [8], s1_i_d [8], s1_r [8], s1_i [8];
    logic signed [6:0] s2_r_d [8], s2_i_d [8], s2_r [8], s2_i [8];
    logic signed [6:0] y_r_d  [8], y_i_d  [8], y_r  [8], y_i  [8];

    assign xp_r = '{x_r_0, x_r_1, x_r_2, x_r_3, x_r_4, x_r_5, x_r_6, x_r_7};
    assign xp_i = '{x_i_0, x_i_1, x_i_2, x_i_3, x_i_4, x_i_5, x_i_6, x_i_7};

`ifdef FFT8_IN_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                a_r[k] <= '0;
                a_i[k] <= '0;
            end
        end else begin
            a_r <= xp_r;
            a_i <= xp_i;
        end
    end
`else
    assign a_r = xp_r;
    assign a_i = xp_i;
`endif

    // Multiply by 181/256, rounding half toward +inf.
    function automatic logic signed [9:0] cmul(input logic signed [9:0] v);
        logic signed [17:0] p;
        p = 18'(v) * 18'sd181 + 18'sd128;
        return 10'(p >>> 8);
    endfunction

    function automatic logic signed [6:0] sat7(input logic signed [9:0] v);
        if (v > 10'sd63)
            return 7'sd63;
        else if (v < -10'sd64)
            return -7'sd64;
        else
            return v[6:0];
    endfunction

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            s1_r_d[2*k]   = 6'(a_r[BR[2*k]]) + 6'(a_r[BR[2*k+1]]);
            s1_i_d[2*k]   = 6'(a_i[BR[2*k]]) + 6'(a_i[BR[2*k+1]]);
            s1_r_d[2*k+1] = 6'(a_r[BR[2*k]]) - 6'(a_r[BR[2*k+1]]);
            s1_i_d[2*k+1] = 6'(a_i[BR[2*k]]) - 6'(a_i[BR[2*k+1]]);
        end
    end

    // Two 4-point DFTs (even half in 0..3, odd half in 4..7); -j is a swap and negate.
    always_comb begin
        for (int g = 0; g < 8; g += 4) begin
            s2_r_d[g]   = 7'(s1_r[g])   + 7'(s1_r[g+2]);
            s2_i_d[g]   = 7'(s1_i[g])   + 7'(s1_i[g+2]);
            s2_r_d[g+2] = 7'(s1_r[g])   - 7'(s1_r[g+2]);
            s2_i_d[g+2] = 7'(s1_i[g])   - 7'(s1_i[g+2]);
            s2_r_d[g+1] = 7'(s1_r[g+1]) + 7'(s1_i[g+3]);
            s2_i_d[g+1] = 7'(s1_i[g+1]) - 7'(s1_r[g+3]);
            s2_r_d[g+3] = 7'(s1_r[g+1]) - 7'(s1_i[g+3]);
            s2_i_d[g+3] = 7'(s1_i[g+1]) + 7'(s1_r[g+3]);
        end
    end

    always_comb begin
        logic signed [9:0] o_r, o_i, t_r, t_i, e_r, e_i;
        for (int k = 0; k < 4; k++) begin
            o_r = 10'(s2_r[k+4]);
            o_i = 10'(s2_i[k+4]);
            e_r = 10'(s2_r[k]);
            e_i = 10'(s2_i[k]);
            case (k)
                1: begin
                    t_r = cmul(o_r + o_i);
                    t_i = cmul(o_i - o_r);
                end
                2: begin
                    t_r = o_i;
                    t_i = -o_r;
                end
                3: begin
                    t_r = cmul(o_i - o_r);
                    t_i = cmul(-(o_r + o_i));
                end
                default: begin
                    t_r = o_r;
                    t_i = o_i;
                end
            endcase
            y_r_d[k]   = sat7(e_r + t_r);
            y_i_d[k]   = sat7(e_i + t_i);
            y_r_d[k+4] = sat7(e_r - t_r);
            y_i_d[k+4] = sat7(e_i - t_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                s1_r[k] <= '0;
                s1_i[k] <= '0;
                s2_r[k] <= '0;
                s2_i[k] <= '0;
                y_r[k]  <= '0;
                y_i[k]  <= '0;
            end
        end else begin
            s1_r <= s1_r_d;
            s1_i <= s1_i_d;
            s2_r <= s2_r_d;
            s2_i <= s2_i_d;
            y_r  <= y_r_d;
            y_i  <= y_i_d;
        end
    end

    assign {y_r_0, y_r_1, y_r_2, y_r_3, y_r_4, y_r_5, y_r_6, y_r_7} =
           {y_r[0], y_r[1], y_r[2], y_r[3], y_r[4], y_r[5], y_r[6], y_r[7]};
    assign {y_i_0, y_i_1, y_i_2, y_i_3, y_i_4, y_i_5, y_i_6, y_i_7} =
           {y_i[0], y_i[1], y_i[2], y_i[3], y_i[4], y_i[5], y_i[6], y_i[7]};
endmodule

// File: tb/tb_fft8_pipelined.sv
// tb/tb_fft8_pipelined.sv - directed self-checking bench for fft8_pipelined
module tb_fft8_pipelined;
    typedef int vec_t [8];

`ifdef FFT8_IN_REG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic signed [4:0] x_r [8];
    logic signed [4:0] x_i [8];
    logic signed [6:0] y_r [8];
    logic signed [6:0] y_i [8];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fft8_pipelined dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x_r_0 (x_r[0]), .x_r_1 (x_r[1]), .x_r_2 (x_r[2]), .x_r_3 (x_r[3]),
        .x_r_4 (x_r[4]), .x_r_5 (x_r[5]), .x_r_6 (x_r[6]), .x_r_7 (x_r[7]),
        .x_i_0 (x_i[0]), .x_i_1 (x_i[1]), .x_i_2 (x_i[2]), .x_i_3 (x_i[3]),
        .x_i_4 (x_i[4]), .x_i_5 (x_i[5]), .x_i_6 (x_i[6]), .x_i_7 (x_i[7]),
        .y_r_0 (y_r[0]), .y_r_1 (y_r[1]), .y_r_2 (y_r[2]), .y_r_3 (y_r[3]),
        .y_r_4 (y_r[4]), .y_r_5 (y_r[5]), .y_r_6 (y_r[6]), .y_r_7 (y_r[7]),
        .y_i_0 (y_i[0]), .y_i_1 (y_i[1]), .y_i_2 (y_i[2]), .y_i_3 (y_i[3]),
        .y_i_4 (y_i[4]), .y_i_5 (y_i[5]), .y_i_6 (y_i[6]), .y_i_7 (y_i[7])
    );

    task automatic set_x(input vec_t r, input vec_t i);
        for (int k = 0; k < 8; k++) begin
            x_r[k] = 5'(r[k]);
            x_i[k] = 5'(i[k]);
        end
    endtask

    task automatic check_y(input string tag, input vec_t er, input vec_t ei);
        for (int k = 0; k < 8; k++) begin
            checks++;
            assert (int'(y_r[k]) === er[k]) else begin
                failures++;
                $error("FAIL %s y_r_%0d got=%0d exp=%0d", tag, k, y_r[k], er[k]);
            end
            checks++;
            assert (int'(y_i[k]) === ei[k]) else begin
                failures++;
                $error("FAIL %s y_i_%0d got=%0d exp=%0d", tag, k, y_i[k], ei[k]);
            end
        end
    endtask

    task automatic apply(input vec_t r, input vec_t i);
        @(negedge clk);
        set_x(r, i);
        repeat (LAT) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t z, dc5, dc15, dcm16, ev_x, ev_yr, ev_yi, tw_x, tw_yr, tw_yi;
        vec_t dc5_y, dc15_y, dcm16_y;
        z      = '{0, 0, 0, 0, 0, 0, 0, 0};
        dc5    = '{5, 5, 5, 5, 5, 5, 5, 5};
        dc15   = '{15, 15, 15, 15, 15, 15, 15, 15};
        dcm16  = '{-16, -16, -16, -16, -16, -16, -16, -16};
        dc5_y  = '{40, 0, 0, 0, 0, 0, 0, 0};
        dc15_y = '{63, 0, 0, 0, 0, 0, 0, 0};
        dcm16_y = '{-64, 0, 0, 0, 0, 0, 0, 0};
        ev_x   = '{14, 0, 6, 0, 5, 0, 15, 0};
        ev_yr  = '{40, 9, -2, 9, 40, 9, -2, 9};
        ev_yi  = '{0, 9, 0, -9, 0, 9, 0, -9};
        tw_x   = '{0, 8, 0, 0, 0, 0, 0, 0};
        tw_yr  = '{8, 6, 0, -6, -8, -6, 0, 6};
        tw_yi  = '{0, -6, -8, -6, 0, 6, 8, 6};

        rst_n = 1'b0;
        set_x(dc5, dc5);
        repeat (10) @(posedge clk);
        #1;
        check_y("reset_hold", z, z);

        @(negedge clk);
        rst_n = 1'b1;

        apply(ev_x, z);
        check_y("even_only", ev_yr, ev_yi);
        apply(dc5, z);
        check_y("dc5", dc5_y, z);
        @(posedge clk);
        #1;
        check_y("dc5_hold", dc5_y, z);
        apply(tw_x, z);
        check_y("twiddle", tw_yr, tw_yi);
        apply(dc15, z);
        check_y("sat_pos", dc15_y, z);
        apply(dcm16, z);
        check_y("sat_neg", dcm16_y, z);

        @(negedge clk);
        set_x(dc5, z);
        @(posedge clk);
        @(negedge clk);
        set_x(ev_x, z);
        @(posedge clk);
        @(negedge clk);
        set_x(z, z);
        repeat (LAT - 2) @(posedge clk);
        #1;
        check_y("stream_0", dc5_y, z);
        @(posedge clk);
        #1;
        check_y("stream_1", ev_yr, ev_yi);
        @(posedge clk);
        #1;
        check_y("stream_2", z, z);

        apply(dc5, z);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_y("async_reset", z, z);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        check_y("post_reset", dc5_y, z);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft8_pipelined.md
Name: fft8_pipelined

Overview:
- Fully parallel, pipelined 8-point complex DFT: radix-2 decimation-in-time, three butterfly stages.
- Every clock it takes 8 complex samples (5-bit signed real and imaginary parts) and produces 8 complex bins in natural order (7-bit signed, saturated).
- Streaming datapath block with no handshake: a new sample set is accepted every cycle.

Parameters:
- None. Widths are fixed: input 5, output 7.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- x_r_0..x_r_7  input  5 each  signed real part of sample n (n = 0..7)
- x_i_0..x_i_7  input  5 each  signed imaginary part of sample n
- y_r_0..y_r_7  output  7 each  signed real part of bin k, registered
- y_i_0..y_i_7  output  7 each  signed imaginary part of bin k, registered

Behaviour:
- Function: X[k] = sum over n of x[n]·W^(nk), with W = e^(-j2π/8). Unscaled (no 1/8 normalisation).
- Output bins are in natural order. Bit-reversal is done by input wiring: stage-1 butterfly pairs are (0,4), (2,6), (1,5), (3,7).
- Stage 1: W^0 butterflies only. Results are 6-bit signed; register them.
- Stage 2: twiddles W^0 and W^2 = -j. Multiplication by -j is a swap and negate, with no multiplier. Results are 7-bit signed; register them.
- Stage 3: twiddles W^0, W^1, W^2, W^3.
  - Only W^1 = c(1-j) and W^3 = -c(1+j), with c = 1/√2, need constant multiplies.
  - c is represented as 181/256.
  - For W^1: re' = (re+im)·181 and im' = (im-re)·181.
  - For W^3: re' = (im-re)·181 and im' = -(re+im)·181.
  - Each product: add 128, then arithmetic shift right by 8 (round half toward +∞). Product width is at least 17 bits.
  - Butterfly sums use at least 10-bit signed intermediates. No internal overflow is allowed.
- Output saturation:
  - Each stage-3 result is clamped to [-64, +63] before the output register.
  - Values inside the range pass through unchanged.
- Latency: 3 register stages.
  - Inputs stable at rising edge t appear on y_* after rising edge t+2 and hold until updated.
  - Throughput: 1 sample set per clock.
  - Holding inputs constant gives constant outputs from edge t+2 onward.
- Reset:
  - rst_n low immediately clears all pipeline registers and all y_r_*/y_i_* to 0, independent of clk.
  - After release, outputs show valid results from the 3rd rising edge onward.
  - Until then, results reflect the zeroed pipeline contents, which give 0 outputs.
  - Reset asserted mid-stream discards all in-flight sets.

Optional Feature:
- Macro FFT8_IN_REG_EN.
- When defined: an extra input register captures all x_* before stage 1. Latency becomes 4 edges (inputs at edge t appear after edge t+3). This register is also cleared by rst_n.
- When undefined: stage 1 is combinational from the ports and latency is 3 edges.
- Arithmetic results are identical in both cases.

Test Plan:
- Reset:
  - Hold rst_n=0 for 10 cycles with nonzero inputs → all y_* = 0.
  - Assert rst_n asynchronously mid-cycle → outputs go to 0 without waiting for a clock edge.
- Even-only real input:
  - Stimulus: x_r = {14,0,6,0,5,0,15,0}, x_i = 0.
  - Required after latency:
    - y_r = {40,9,-2,9,40,9,-2,9}
    - y_i = {0,9,0,-9,0,9,0,-9}
- Constant (DC) input:
  - Stimulus: all x_r = 5, x_i = 0.
  - Required: y_r_0 = 40; every other y_* = 0.
- Twiddle rounding:
  - Stimulus: x_r_1 = 8, all other inputs 0.
  - Required:
    - y_r = {8,6,0,-6,-8,-6,0,6}
    - y_i = {0,-6,-8,-6,0,6,8,6}
- Saturation:
  - All x_r = 15, x_i = 0 → y_r_0 = 63, all other outputs 0.
  - All x_r = -16 → y_r_0 = -64.
- Streaming and latency:
  - Change the input set on consecutive edges (DC 5, then the even-only vector above, then zeros).
  - Required: outputs follow with exactly 3-edge latency (4 with FFT8_IN_REG_EN), one result per cycle, no bubbles.
